// File: rtl/layer_scan_ctrl_if.sv
// Signal bundle between the layer scan controller, the frame buffer RAM and
// the latch driver of the 8x8x8 LED cube.
interface layer_scan_ctrl_if;
    logic       enable;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       lat_start;
    logic [2:0] lat_idx;
    logic [7:0] lat_data;
    logic       lat_done;
    logic [7:0] layer_en;
    logic       frame_tick;
    logic       err;

    modport master (
        input  enable, rd_data, lat_done,
        output rd_addr, lat_start, lat_idx, lat_data, layer_en, frame_tick, err
    );

    modport slave (
        output enable, rd_data, lat_done,
        input  rd_addr, lat_start, lat_idx, lat_data, layer_en, frame_tick, err
    );
endinterface

// File: rtl/layer_scan_ctrl.sv
// Layer scan controller: per layer, blanks the cube, loads the 8 row latches
// from the frame buffer through the start/done handshake, then shows the layer.
module layer_scan_ctrl #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4,
    parameter int DONE_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    layer_scan_ctrl_if.master bus
);

    localparam int CNT_MAX_A = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > DONE_TIMEOUT) ? CNT_MAX_A : DONE_TIMEOUT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] BLANK_LOAD  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(DONE_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BLANK     = 3'd1,
        FETCH     = 3'd2,
        CAPTURE   = 3'd3,
        ISSUE     = 3'd4,
        WAIT_DONE = 3'd5,
        SHOW      = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       layer_q, layer_d;
    logic [2:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       rd_addr_q, rd_addr_d;
    logic             lat_start_q, lat_start_d;
    logic [2:0]       lat_idx_q, lat_idx_d;
    logic [7:0]       lat_data_q, lat_data_d;
    logic [7:0]       layer_en_q, layer_en_d;
    logic             frame_tick_q, frame_tick_d;
    logic             err_q, err_d;

    // Next-state logic; cnt_q counts down in BLANK/SHOW and up in WAIT_DONE.
    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        lat_idx_d  = lat_idx_q;
        lat_data_d = lat_data_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                layer_d = 3'd0;
                row_d   = 3'd0;
                if (bus.enable) begin
                    state_d = BLANK;
                    cnt_d   = BLANK_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            BLANK: begin
                if (cnt_q == CNT_ZERO) begin
                    row_d   = 3'd0;
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            FETCH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                lat_data_d = bus.rd_data;
                lat_idx_d  = row_q;
                state_d    = ISSUE;
            end
            ISSUE: begin
                // A done pulse here belongs to no transfer we are waiting on.
                state_d = WAIT_DONE;
                cnt_d   = CNT_ONE;
            end
            WAIT_DONE: begin
                if (bus.lat_done || (cnt_q == TIMEOUT_VAL)) begin
                    if (!bus.lat_done) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (row_q == 3'd7) begin
                        state_d = SHOW;
                        cnt_d   = DWELL_LOAD;
                    end else begin
                        row_d   = row_q + 3'd1;
                        state_d = FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SHOW: begin
                if (cnt_q == CNT_ZERO) begin
                    if (bus.enable) begin
                        layer_d = layer_q + 3'd1;
                        state_d = BLANK;
                        cnt_d   = BLANK_LOAD;
                    end else begin
                        layer_d = 3'd0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                layer_d = 3'd0;
                row_d   = 3'd0;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output next values are derived from the next state so every registered
    // output lines up with the state it belongs to.
    always_comb begin
        if (state_d == FETCH) begin
            rd_addr_d = {layer_d, row_d};
        end else begin
            rd_addr_d = rd_addr_q;
        end
        lat_start_d = (state_d == ISSUE);
        if (state_d == SHOW) begin
            layer_en_d = 8'd1 << layer_d;
        end else begin
            layer_en_d = 8'd0;
        end
        frame_tick_d = (state_d == SHOW) && (cnt_d == CNT_ZERO) && (layer_d == 3'd7);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            layer_q      <= 3'd0;
            row_q        <= 3'd0;
            cnt_q        <= CNT_ZERO;
            rd_addr_q    <= 6'd0;
            lat_start_q  <= 1'b0;
            lat_idx_q    <= 3'd0;
            lat_data_q   <= 8'd0;
            layer_en_q   <= 8'd0;
            frame_tick_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            rd_addr_q    <= rd_addr_d;
            lat_start_q  <= lat_start_d;
            lat_idx_q    <= lat_idx_d;
            lat_data_q   <= lat_data_d;
            layer_en_q   <= layer_en_d;
            frame_tick_q <= frame_tick_d;
            err_q        <= err_d;
        end
    end

    assign bus.rd_addr    = rd_addr_q;
    assign bus.lat_start  = lat_start_q;
    assign bus.lat_idx    = lat_idx_q;
    assign bus.lat_data   = lat_data_q;
    assign bus.layer_en   = layer_en_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_layer_scan_ctrl.sv
// Self-checking bench for layer_scan_ctrl with a frame buffer model and a
// latch driver responder returning done 4 cycles after each start.
module tb_layer_scan_ctrl;

    localparam int DONE_N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    layer_scan_ctrl_if bus_if ();

    layer_scan_ctrl #(
        .DWELL_CYCLES(1000),
        .BLANK_CYCLES(4),
        .DONE_TIMEOUT(15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if.master)
    );

    typedef struct {
        int         cyc;
        logic [5:0] addr;
        logic [2:0] idx;
        logic [7:0] data;
    } start_t;

    typedef struct {
        int         cyc;
        logic [7:0] en;
    } rise_t;

    typedef struct {
        logic [5:0] addr;
        logic [2:0] idx;
        logic [7:0] data;
    } vec_t;

    logic [7:0] ram [64];
    int         dcnt;
    logic       resp_done;
    logic       drop_all = 1'b0;
    logic       drop_row3 = 1'b0;
    logic       early_done = 1'b0;

    int     cyc = 0;
    start_t st_q[$];
    rise_t  rise_q[$];
    int     len_q[$];
    int     tick_q[$];
    int     err_cyc = -1;
    int     overlap = 0;
    int     run_start = 0;
    logic [7:0] prev_en = 8'd0;

    int tests_run = 0;
    int tests_failed = 0;
    vec_t vecs [16];

    // Frame buffer: data appears one cycle after the address.
    always @(posedge clk) bus_if.rd_data <= ram[bus_if.rd_addr];

    // Latch driver model; early_done also pulses done during the ISSUE cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            dcnt      <= 0;
            resp_done <= 1'b0;
        end else begin
            resp_done <= 1'b0;
            if (bus_if.lat_start) begin
                if (drop_all || (drop_row3 && bus_if.lat_idx == 3'd3 && bus_if.rd_addr[5:3] == 3'd0))
                    dcnt <= 0;
                else
                    dcnt <= DONE_N - 1;
            end else if (dcnt > 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1) resp_done <= 1'b1;
            end
        end
    end
    assign bus_if.lat_done = resp_done | (early_done & bus_if.lat_start);

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Event recorder sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (bus_if.lat_start) begin
            st_q.push_back('{cyc: cyc, addr: bus_if.rd_addr, idx: bus_if.lat_idx, data: bus_if.lat_data});
            if (bus_if.layer_en != 8'd0) overlap++;
        end
        if ($countones(bus_if.layer_en) > 1) overlap++;
        if (bus_if.layer_en != prev_en) begin
            if (prev_en != 8'd0) len_q.push_back(cyc - run_start);
            if (bus_if.layer_en != 8'd0) begin
                rise_q.push_back('{cyc: cyc, en: bus_if.layer_en});
                run_start = cyc;
            end
        end
        prev_en = bus_if.layer_en;
        if (bus_if.frame_tick) tick_q.push_back(cyc);
        if (bus_if.err && err_cyc < 0) err_cyc = cyc;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, " rd_addr"},    32'(bus_if.rd_addr),    32'd0);
        check({nm, " lat_start"},  32'(bus_if.lat_start),  32'd0);
        check({nm, " lat_idx"},    32'(bus_if.lat_idx),    32'd0);
        check({nm, " lat_data"},   32'(bus_if.lat_data),   32'd0);
        check({nm, " layer_en"},   32'(bus_if.layer_en),   32'd0);
        check({nm, " frame_tick"}, 32'(bus_if.frame_tick), 32'd0);
        check({nm, " err"},        32'(bus_if.err),        32'd0);
    endtask

    task automatic wait_starts(input int n, input int budget, input string nm);
        int k = 0;
        while (st_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(nm, 32'(st_q.size() >= n), 32'd1);
    endtask

    task automatic wait_rises(input int n, input int budget, input string nm);
        int k = 0;
        while (rise_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(nm, 32'(rise_q.size() >= n), 32'd1);
    endtask

    task automatic wait_lens(input int n, input int budget, input string nm);
        int k = 0;
        while (len_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(nm, 32'(len_q.size() >= n), 32'd1);
    endtask

    task automatic clear_events();
        st_q.delete();
        rise_q.delete();
        len_q.delete();
        tick_q.delete();
        err_cyc = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_events();
    endtask

    initial begin
        int k;
        bus_if.enable = 1'b0;
        for (int a = 0; a < 64; a++) ram[a] = 8'h40 + 8'(a);
        // First two layers: addresses 0..15, row index = addr mod 8, byte = 0x40 + addr.
        for (int i = 0; i < 16; i++) begin
            vecs[i].addr = 6'(i);
            vecs[i].idx  = 3'(i % 8);
            vecs[i].data = 8'h40 + 8'(i);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        clear_events();

        // Normal scan, with a spurious done during every ISSUE cycle
        early_done = 1'b1;
        bus_if.enable = 1'b1;
        wait_starts(16, 3000, "two layers of starts");
        for (int i = 0; i < 16; i++) begin
            if (i < st_q.size()) begin
                check($sformatf("vec%0d rd_addr", i),  32'(st_q[i].addr), 32'(vecs[i].addr));
                check($sformatf("vec%0d lat_idx", i),  32'(st_q[i].idx),  32'(vecs[i].idx));
                check($sformatf("vec%0d lat_data", i), 32'(st_q[i].data), 32'(vecs[i].data));
            end
        end
        for (int i = 1; i < 8; i++)
            if (i < st_q.size())
                check($sformatf("row%0d spacing", i), 32'(st_q[i].cyc - st_q[i-1].cyc), 32'd7);
        if (rise_q.size() > 0 && st_q.size() > 7) begin
            check("show after row7 start", 32'(rise_q[0].cyc - st_q[7].cyc), 32'd5);
            check("first layer_en", 32'(rise_q[0].en), 32'h01);
        end

        wait_rises(9, 10000, "nine layer shows");
        for (int i = 0; i < 9; i++)
            if (i < rise_q.size())
                check($sformatf("layer_en seq %0d", i), 32'(rise_q[i].en), 32'(8'd1 << (i % 8)));
        for (int i = 1; i < 9; i++)
            if (i < rise_q.size())
                check($sformatf("layer period %0d", i), 32'(rise_q[i].cyc - rise_q[i-1].cyc), 32'd1060);
        for (int i = 0; i < 8; i++)
            if (i < len_q.size())
                check($sformatf("dwell len %0d", i), 32'(len_q[i]), 32'd1000);
        check("frame_tick count", 32'(tick_q.size()), 32'd1);
        if (tick_q.size() > 0 && rise_q.size() > 7)
            check("frame_tick cycle", 32'(tick_q[0] - rise_q[7].cyc), 32'd999);
        check("err stays 0", 32'(bus_if.err), 32'd0);
        early_done = 1'b0;

        // Timeout on layer 0 row 3
        do_reset();
        drop_row3 = 1'b1;
        bus_if.enable = 1'b1;
        wait_starts(6, 300, "timeout starts");
        if (st_q.size() > 5) begin
            check("timeout row idx", 32'(st_q[3].idx), 32'd3);
            check("next row after timeout", 32'(st_q[4].addr), 32'h04);
            check("timeout spacing", 32'(st_q[4].cyc - st_q[3].cyc), 32'd18);
            check("err set cycle", 32'(err_cyc - st_q[3].cyc), 32'd16);
            check("row5 spacing", 32'(st_q[5].cyc - st_q[4].cyc), 32'd7);
        end
        wait_rises(1, 300, "show after timeout");
        check("err sticky", 32'(bus_if.err), 32'd1);
        drop_row3 = 1'b0;

        // Enable dropped during layer 2 row 5
        do_reset();
        check("err cleared by reset", 32'(bus_if.err), 32'd0);
        bus_if.enable = 1'b1;
        k = 0;
        while (!(st_q.size() > 0 && st_q[st_q.size()-1].addr == 6'h15) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check("reached layer2 row5", 32'(k < 4000), 32'd1);
        bus_if.enable = 1'b0;
        wait_lens(3, 2000, "layer2 show ends");
        if (rise_q.size() > 2 && len_q.size() > 2) begin
            check("layer2 en", 32'(rise_q[2].en), 32'h04);
            check("layer2 full dwell", 32'(len_q[2]), 32'd1000);
        end
        check("layer2 starts", 32'(st_q.size()), 32'd24);
        if (st_q.size() > 23) check("layer2 last row", 32'(st_q[23].addr), 32'h17);
        repeat (100) @(negedge clk);
        check("idle no starts", 32'(st_q.size()), 32'd24);
        check("idle layer_en", 32'(bus_if.layer_en), 32'd0);
        check("idle no shows", 32'(rise_q.size()), 32'd3);
        check("no frame_tick", 32'(tick_q.size()), 32'd0);
        bus_if.enable = 1'b1;
        wait_starts(25, 50, "restart start");
        if (st_q.size() > 24) check("restart rd_addr", 32'(st_q[24].addr), 32'h00);

        // Reset while waiting for done
        do_reset();
        ram[0] = 8'hA5;
        drop_all = 1'b1;
        bus_if.enable = 1'b1;
        wait_starts(1, 50, "A5 start");
        if (st_q.size() > 0) check("A5 lat_data", 32'(st_q[0].data), 32'hA5);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        bus_if.enable = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid reset");
        rst_n = 1'b1;
        drop_all = 1'b0;
        repeat (40) @(negedge clk);
        check("no start after reset", 32'(st_q.size()), 32'd1);
        bus_if.enable = 1'b1;
        wait_starts(2, 50, "start after re-enable");
        if (st_q.size() > 1) check("re-enable rd_addr", 32'(st_q[1].addr), 32'h00);
        ram[0] = 8'h40;

        check("layer_en during latching", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
